// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and valid/ready output.
// Flags framing errors (stop bit low) and overruns (byte completed while FIFO full).
module uart_rx_capture #(
  parameter logic [31:0] CLK_FREQ_HZ = 32'd12_500_000,
  parameter int          BAUD        = 115200,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_rx,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int DIV  = (int'(CLK_FREQ_HZ) + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [1:0] sync_reg;
  logic [2:0] sync_chain;
  logic       rx_s;

  assign sync_chain = {sync_reg, i_rx};
  assign rx_s       = sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rstn) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= sync_chain[gi];
      end
    end
  endgenerate

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg, overrun_next;
  logic          push_req;
  logic          sample;

  assign sample = (cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    push_req       = 1'b0;
    if (state_reg != S_IDLE)
      cnt_next = sample ? DIV_M1 : cnt_reg - 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_M1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = 3'd0;
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_s) begin
            push_req   = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Hold off until the line returns high so a long break is one error, not many.
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          full, pop, push;

  assign full = (level_reg == DEPTH_L);
  assign pop  = o_valid & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = push_req & (~full | pop);

  assign overrun_next = push_req & full & ~pop;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)      level_next = level_reg + 1'b1;
    else if (pop && !push) level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
      level_reg     <= level_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  assign o_valid     = (level_reg != '0);
  assign o_data      = o_valid ? mem[rd_ptr_reg] : 8'h00;
  assign o_level     = level_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Self-checking bench for uart_rx_capture: table-driven frames, timing corner cases,
// and randomized frames/baud/back-pressure scored against a byte-queue model.
module tb_uart_rx_capture;

  localparam int DIV = 109;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic [4:0] o_level;

  always #5 clk = ~clk;

  uart_rx_capture dut (
    .clk(clk), .rstn(rstn), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_level(o_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every accepted byte and counts flag pulses, sampled mid-cycle.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         valid_cnt = 0;
  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      got_q.push_back(o_data);
      got_cyc.push_back(cyc);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_overrun) ovr_cnt++;
    if (o_valid) valid_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] got_byte(input int i);
    if (i < got_q.size()) return {24'd0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int got_time(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc);
    i_rx = 1'b0;
    tick(bitc);
    for (int k = 0; k < 8; k++) begin
      i_rx = d[k];
      tick(bitc);
    end
    i_rx = stop;
    tick(bitc);
    i_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bitc;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] exp_q[$];
  bit   done;
  int   base, fbase, obase, vbase, p, nbad;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 109, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 107, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 111, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 109, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 109, 1, 0};
    vecs[5] = '{8'h5A, 1'b0, 111, 0, 1};
    vecs[6] = '{8'hC3, 1'b1, 108, 1, 0};

    tick(5);
    check("reset_valid", {31'd0, o_valid}, 0);
    check("reset_data", {24'd0, o_data}, 0);
    check("reset_level", {27'd0, o_level}, 0);
    check("reset_flags", {30'd0, o_frame_err, o_overrun}, 0);
    rstn = 1'b1;
    tick(5);

    // Single byte: exact latency from the falling edge to o_valid.
    i_ready = 1'b1;
    base = got_q.size(); vbase = valid_cnt; p = cyc;
    send_frame(8'h55, 1'b1, DIV);
    tick(50);
    check("single_count", got_q.size() - base, 1);
    check("single_data", got_byte(base), 8'h55);
    check("single_latency", got_time(base) - p, 1038);
    check("single_valid_cycles", valid_cnt - vbase, 1);
    check("single_level", {27'd0, o_level}, 0);

    for (int v = 0; v < 7; v++) begin
      base = got_q.size(); fbase = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].bitc);
      tick(200);
      check($sformatf("vec%0d_push", v), got_q.size() - base, vecs[v].exp_push);
      if (vecs[v].exp_push != 0) check($sformatf("vec%0d_data", v), got_byte(base), vecs[v].data);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - fbase, vecs[v].exp_ferr);
    end

    // Back-to-back frames held, then drained on consecutive cycles.
    i_ready = 1'b0;
    send_frame(8'h00, 1'b1, DIV);
    send_frame(8'hFF, 1'b1, DIV);
    send_frame(8'hA5, 1'b1, DIV);
    tick(50);
    check("b2b_level", {27'd0, o_level}, 3);
    base = got_q.size();
    i_ready = 1'b1;
    tick(10);
    check("b2b_count", got_q.size() - base, 3);
    check("b2b_d0", got_byte(base), 8'h00);
    check("b2b_d1", got_byte(base + 1), 8'hFF);
    check("b2b_d2", got_byte(base + 2), 8'hA5);
    check("b2b_gap1", got_time(base + 1) - got_time(base), 1);
    check("b2b_gap2", got_time(base + 2) - got_time(base + 1), 1);

    // Glitch shorter than half a bit.
    base = got_q.size(); fbase = ferr_cnt; obase = ovr_cnt;
    i_rx = 1'b0;
    tick(20);
    i_rx = 1'b1;
    tick(200);
    check("glitch_push", got_q.size() - base, 0);
    check("glitch_flags", (ferr_cnt - fbase) + (ovr_cnt - obase), 0);
    send_frame(8'h96, 1'b1, DIV);
    tick(50);
    check("glitch_next", got_byte(base), 8'h96);

    // Framing error followed by a long break.
    base = got_q.size(); fbase = ferr_cnt;
    send_frame(8'h3C, 1'b0, DIV);
    i_rx = 1'b0;
    tick(2000);
    i_rx = 1'b1;
    tick(50);
    check("ferr_pulses", ferr_cnt - fbase, 1);
    check("ferr_push", got_q.size() - base, 0);
    check("ferr_level", {27'd0, o_level}, 0);
    send_frame(8'h81, 1'b1, DIV);
    tick(50);
    check("ferr_next", got_byte(base), 8'h81);

    // Overrun on the 17th byte.
    i_ready = 1'b0;
    obase = ovr_cnt;
    for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1, DIV);
    tick(20);
    check("ovr_level_full", {27'd0, o_level}, 16);
    check("ovr_none_yet", ovr_cnt - obase, 0);
    send_frame(8'h10, 1'b1, DIV);
    tick(20);
    check("ovr_pulses", ovr_cnt - obase, 1);
    check("ovr_level_kept", {27'd0, o_level}, 16);
    base = got_q.size();
    i_ready = 1'b1;
    tick(30);
    check("ovr_drain_count", got_q.size() - base, 16);
    for (int b = 0; b < 16; b++) check($sformatf("ovr_drain%0d", b), got_byte(base + b), b);
    check("ovr_level_empty", {27'd0, o_level}, 0);

    // Reset during bit 4 of 0xC3 with one byte already queued.
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, DIV);
    tick(20);
    check("rst_prefill", {27'd0, o_level}, 1);
    i_rx = 1'b0;
    tick(DIV);
    for (int k = 0; k < 4; k++) begin
      i_rx = (k < 2);
      tick(DIV);
    end
    i_rx = 1'b0;
    tick(DIV / 2);
    rstn = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_data", {24'd0, o_data}, 0);
    check("rst_level", {27'd0, o_level}, 0);
    check("rst_flags", {30'd0, o_frame_err, o_overrun}, 0);
    i_rx = 1'b1;
    tick(5);
    rstn = 1'b1;
    tick(300);
    base = got_q.size();
    i_ready = 1'b1;
    send_frame(8'h7E, 1'b1, DIV);
    tick(50);
    check("rst_next_count", got_q.size() - base, 1);
    check("rst_next_data", got_byte(base), 8'h7E);

    // Randomized frames, baud within +-2%, random back-pressure.
    exp_q.delete();
    base = got_q.size(); fbase = ferr_cnt; nbad = 0;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          logic [7:0] d;
          logic       s;
          d = 8'($urandom);
          s = ($urandom_range(0, 5) != 0);
          send_frame(d, s, $urandom_range(107, 111));
          if (s) exp_q.push_back(d);
          else nbad++;
          tick(s ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          i_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    i_ready = 1'b1;
    tick(50);
    check("rand_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_byte%0d", i), got_byte(base + i), exp_q[i]);
    check("rand_ferr", ferr_cnt - fbase, nbad);
    check("rand_level", {27'd0, o_level}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
